// File: rtl/frame_deserializer_if.sv
// Serial receive bus of the frame deserializer.
//   rx_bit          : serial line, one bit per clk, MSB first, idle 0
//   rx_frame        : last accepted 16-bit frame {SFD, dst, src, payload}
//   frame_rx_valid  : one-cycle pulse when rx_frame is updated
//   rx_src          : src field of the last accepted frame
//   rx_payload      : payload field of the last accepted frame
//   accept_count    : saturating count of accepted frames
//   drop_count      : saturating count of filtered frames
//   busy            : high while a frame body is being received
// slave  : the deserializer side (consumes rx_bit, drives results)
// master : the line/host side (drives rx_bit, observes results)
interface frame_deserializer_if;
    logic        rx_bit;
    logic [15:0] rx_frame;
    logic        frame_rx_valid;
    logic [3:0]  rx_src;
    logic [3:0]  rx_payload;
    logic [7:0]  accept_count;
    logic [7:0]  drop_count;
    logic        busy;

    modport slave (
        input  rx_bit,
        output rx_frame, frame_rx_valid, rx_src, rx_payload,
               accept_count, drop_count, busy
    );

    modport master (
        output rx_bit,
        input  rx_frame, frame_rx_valid, rx_src, rx_payload,
               accept_count, drop_count, busy
    );
endinterface

// File: rtl/frame_deserializer.sv
// Serial frame receiver with destination/source address filtering.
//
// state | meaning
// ------+------------------------------------------------------------
// HUNT  | sliding 4-bit window searches for the SFD 4'b0101
// RECV  | shifting in the 12 body bits {dst, src, payload}
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : frame_deserializer_if.slave (rx_bit in, results out)
//
// The accept/drop decision is registered on the cycle the last bit is
// sampled; outputs and counters update on the following edge. That second
// stage is independent of the FSM, so a new frame can start immediately.
module frame_deserializer #(
    parameter logic [3:0] MAC_ADDRESS = 4'hA,
    parameter logic [3:0] BCAST_ADDR  = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_deserializer_if.slave   bus
);

    localparam logic [3:0] SFD = 4'b0101;

    typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

    state_t      state_q,     state_d;
    logic [3:0]  win_q,       win_d;
    logic [2:0]  fill_q,      fill_d;
    logic [3:0]  bit_cnt_q,   bit_cnt_d;
    logic [11:0] sr_q,        sr_d;
    logic [15:0] pend_q,      pend_d;
    logic        acc_pend_q,  acc_pend_d;
    logic        drp_pend_q,  drp_pend_d;
    logic [15:0] rx_frame_q,  rx_frame_d;
    logic [3:0]  rx_src_q,    rx_src_d;
    logic [3:0]  rx_pay_q,    rx_pay_d;
    logic        valid_q,     valid_d;
    logic [7:0]  acc_cnt_q,   acc_cnt_d;
    logic [7:0]  drp_cnt_q,   drp_cnt_d;
    logic        busy_q,      busy_d;

    logic        addr_ok;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        fill_d     = fill_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        pend_d     = pend_q;
        acc_pend_d = 1'b0;
        drp_pend_d = 1'b0;
        rx_frame_d = rx_frame_q;
        rx_src_d   = rx_src_q;
        rx_pay_d   = rx_pay_q;
        valid_d    = 1'b0;
        acc_cnt_d  = acc_cnt_q;
        drp_cnt_d  = drp_cnt_q;
        addr_ok    = 1'b0;

        case (state_q)
            HUNT: begin
                win_d  = {win_q[2:0], bus.rx_bit};
                fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
                // The fill requirement keeps a freshly cleared window
                // (0000 + "101") from masquerading as an SFD.
                if (win_d == SFD && fill_d == 3'd4) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd0;
                end
            end
            RECV: begin
                sr_d = {sr_q[10:0], bus.rx_bit};
                if (bit_cnt_q == 4'd11) begin
                    state_d   = HUNT;
                    win_d     = 4'd0;
                    fill_d    = 3'd0;
                    bit_cnt_d = 4'd0;
                    pend_d    = {SFD, sr_d};
                    // Own src means the frame looped back through the switch.
                    addr_ok   = (sr_d[11:8] == MAC_ADDRESS || sr_d[11:8] == BCAST_ADDR)
                                && (sr_d[7:4] != MAC_ADDRESS);
                    acc_pend_d = addr_ok;
                    drp_pend_d = !addr_ok;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: state_d = HUNT;
        endcase

        if (acc_pend_q) begin
            rx_frame_d = pend_q;
            rx_src_d   = pend_q[7:4];
            rx_pay_d   = pend_q[3:0];
            valid_d    = 1'b1;
            if (acc_cnt_q != 8'hFF) acc_cnt_d = acc_cnt_q + 8'd1;
        end
        if (drp_pend_q && drp_cnt_q != 8'hFF) drp_cnt_d = drp_cnt_q + 8'd1;

        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            win_q      <= 4'd0;
            fill_q     <= 3'd0;
            bit_cnt_q  <= 4'd0;
            sr_q       <= 12'd0;
            pend_q     <= 16'd0;
            acc_pend_q <= 1'b0;
            drp_pend_q <= 1'b0;
            rx_frame_q <= 16'h0000;
            rx_src_q   <= 4'd0;
            rx_pay_q   <= 4'd0;
            valid_q    <= 1'b0;
            acc_cnt_q  <= 8'd0;
            drp_cnt_q  <= 8'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            fill_q     <= fill_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            pend_q     <= pend_d;
            acc_pend_q <= acc_pend_d;
            drp_pend_q <= drp_pend_d;
            rx_frame_q <= rx_frame_d;
            rx_src_q   <= rx_src_d;
            rx_pay_q   <= rx_pay_d;
            valid_q    <= valid_d;
            acc_cnt_q  <= acc_cnt_d;
            drp_cnt_q  <= drp_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rx_frame       = rx_frame_q;
    assign bus.rx_src         = rx_src_q;
    assign bus.rx_payload     = rx_pay_q;
    assign bus.frame_rx_valid = valid_q;
    assign bus.accept_count   = acc_cnt_q;
    assign bus.drop_count     = drp_cnt_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_frame_deserializer.sv
// Testbench for frame_deserializer (MAC_ADDRESS=A, BCAST_ADDR=F).
// Stimulus pushes expected accepted frames and their arrival cycle into a
// scoreboard queue; an independent monitor pops and compares on each pulse.
module tb_frame_deserializer;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    int   exp_acc = 0;
    int   exp_drp = 0;

    typedef struct {
        logic [15:0] f;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    frame_deserializer_if bus_if ();

    frame_deserializer #(.MAC_ADDRESS(4'hA), .BCAST_ADDR(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (bus_if.busy === 1'b1) busy_cnt++;
        if (!rst && bus_if.frame_rx_valid !== 1'b0) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: frame_rx_valid=%b with empty scoreboard, rx_frame=0x%0h (cycle %0d)",
                         bus_if.frame_rx_valid, bus_if.rx_frame, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rx_frame",   int'(bus_if.rx_frame),   int'(e.f));
                chk("rx_src",     int'(bus_if.rx_src),     int'(e.f[7:4]));
                chk("rx_payload", int'(bus_if.rx_payload), int'(e.f[3:0]));
                chk("latency",    cyc,                     e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_if.rx_bit = 1'b0;
        end
    endtask

    // First bit driven at negedge with cycle C is sampled at edge T=C+1;
    // the pulse is expected at T+16.
    task automatic send_frame(input logic [15:0] f, input bit acc);
        int start;
        start = 0;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            if (i == 15) start = cyc;
            bus_if.rx_bit = f[i];
        end
        if (acc) begin
            exp_t e;
            e.f   = f;
            e.cyc = start + 17;
            sbq.push_back(e);
            if (exp_acc < 255) exp_acc++;
        end else begin
            if (exp_drp < 255) exp_drp++;
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_accept_count"}, int'(bus_if.accept_count), exp_acc);
        chk({tag, "_drop_count"},   int'(bus_if.drop_count),   exp_drp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_frame"},     int'(bus_if.rx_frame),       0);
        chk({tag, "_rx_src"},       int'(bus_if.rx_src),         0);
        chk({tag, "_rx_payload"},   int'(bus_if.rx_payload),     0);
        chk({tag, "_valid"},        int'(bus_if.frame_rx_valid), 0);
        chk({tag, "_busy"},         int'(bus_if.busy),           0);
        chk({tag, "_accept_count"}, int'(bus_if.accept_count),   0);
        chk({tag, "_drop_count"},   int'(bus_if.drop_count),     0);
    endtask

    initial begin
        int b0;
        logic [15:0] f;
        rst = 1'b1;
        bus_if.rx_bit = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        idle(5);

        // Basic accept with latency and busy width.
        b0 = busy_cnt;
        send_frame(16'h5AB7, 1'b1);
        idle(4);
        chk_counts("t1");
        chk("t1_busy_cycles", busy_cnt - b0, 12);
        chk("t1_rx_frame", int'(bus_if.rx_frame), 16'h5AB7);

        // Wrong destination is dropped; broadcast accepted.
        send_frame(16'h5CB3, 1'b0);
        idle(4);
        chk_counts("t2_drop");
        chk("t2_rx_frame_held", int'(bus_if.rx_frame), 16'h5AB7);
        chk("t2_rx_payload_held", int'(bus_if.rx_payload), 4'h7);
        send_frame(16'h5FD9, 1'b1);
        idle(4);
        chk_counts("t2_bcast");
        chk("t2_rx_payload", int'(bus_if.rx_payload), 4'h9);

        // Loopback (src == own MAC) dropped.
        send_frame(16'h5AA1, 1'b0);
        idle(4);
        chk_counts("t3");
        chk("t3_rx_frame_held", int'(bus_if.rx_frame), 16'h5FD9);

        // Cleared window followed by 1,0,1 must not detect.
        b0 = busy_cnt;
        send_frame(16'h5AB5, 1'b1);
        @(negedge clk); bus_if.rx_bit = 1'b1;
        @(negedge clk); bus_if.rx_bit = 1'b0;
        @(negedge clk); bus_if.rx_bit = 1'b1;
        idle(20);
        chk_counts("partial");
        chk("partial_busy_cycles", busy_cnt - b0, 12);

        // Back-to-back frames, payload 0101 in the first must not resync.
        b0 = busy_cnt;
        send_frame(16'h5AB5, 1'b1);
        send_frame(16'h5AC2, 1'b1);
        idle(4);
        chk_counts("b2b");
        chk("b2b_busy_cycles", busy_cnt - b0, 24);
        chk("b2b_rx_frame", int'(bus_if.rx_frame), 16'h5AC2);

        // Reset at the 6th body bit discards the partial frame.
        f = 16'h5AB7;
        for (int i = 15; i >= 7; i--) begin
            @(negedge clk);
            bus_if.rx_bit = f[i];
        end
        @(negedge clk);
        bus_if.rx_bit = f[6];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.rx_bit = 1'b0;
        chk_all_zero("midrst");
        exp_acc = 0;
        exp_drp = 0;
        idle(3);
        send_frame(16'h5AD4, 1'b1);
        idle(4);
        chk_counts("t5");
        chk("t5_rx_payload", int'(bus_if.rx_payload), 4'h4);

        // Accept counter saturation; every frame must still pulse.
        for (int i = 0; i < 260; i++) begin
            f = 16'h5AB0 | 16'(i & 15);
            send_frame(f, 1'b1);
        end
        idle(4);
        chk_counts("acc_sat");
        chk("acc_sat_value", int'(bus_if.accept_count), 8'hFF);

        // Drop counter saturation.
        for (int i = 0; i < 257; i++) send_frame(16'h5CB3, 1'b0);
        idle(4);
        chk_counts("drp_sat");
        chk("drp_sat_value", int'(bus_if.drop_count), 8'hFF);

        idle(20);
        chk("missing_pulses", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
